// File: rtl/sim_halt_ctrl.sv
// Simulation halt controller: RUN -> DRAIN -> DONE sequencing, halt reason capture, commit logging.
// Optional stall watchdog (halt reason 3) is built only when SIM_STALL_WATCHDOG_EN is defined.
module sim_halt_ctrl #(
  parameter int unsigned DATA_LEN     = 64,
  parameter int unsigned MAX_CYCLES   = 400000000,
  parameter int unsigned STALL_LIMIT  = 100000,
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] pc,
  input  logic                inst_commit,
  input  logic                cpu_ebreak_sign,
  input  logic [DATA_LEN-1:0] a0_value,
  output logic                halt_req,
  output logic                log_en,
  output logic [DATA_LEN-1:0] log_pc,
  output logic                sim_done,
  output logic [1:0]          halt_reason,
  output logic                trap_good,
  output logic [DATA_LEN-1:0] cycle_count,
  output logic [DATA_LEN-1:0] commit_count
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]       DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]       DRAIN_ONE  = DW'(1);
  localparam logic [DATA_LEN-1:0] CYC_LAST   = DATA_LEN'(MAX_CYCLES - 1);
  localparam logic [DATA_LEN-1:0] ONE        = DATA_LEN'(1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [DATA_LEN-1:0] cycle_q, cycle_d;
  logic [DATA_LEN-1:0] commit_q, commit_d;
  logic [DATA_LEN-1:0] log_pc_q, log_pc_d;
  logic                log_en_q, log_en_d;
  logic                halt_q, halt_d;
  logic                done_q, done_d;
  logic [1:0]          reason_q, reason_d;
  logic                trap_q, trap_d;
  logic                timeout_trig, stall_trig, any_trig, active;

`ifdef SIM_STALL_WATCHDOG_EN
  localparam int unsigned SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
  localparam logic [SW-1:0] STALL_ONE  = SW'(1);
  logic [SW-1:0] stall_q, stall_d;

  always_comb begin
    stall_trig = (stall_q == STALL_LAST) && !inst_commit;
    stall_d    = stall_q;
    if (state_q == S_RUN) stall_d = inst_commit ? '0 : stall_q + STALL_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  always_comb stall_trig = 1'b0;
`endif

  always_comb begin
    timeout_trig = (cycle_q == CYC_LAST);
    any_trig     = cpu_ebreak_sign || timeout_trig || stall_trig;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_RUN;
      drain_q  <= '0;
      cycle_q  <= '0;
      commit_q <= '0;
      log_pc_q <= '0;
      log_en_q <= 1'b0;
      halt_q   <= 1'b0;
      done_q   <= 1'b0;
      reason_q <= '0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      cycle_q  <= cycle_d;
      commit_q <= commit_d;
      log_pc_q <= log_pc_d;
      log_en_q <= log_en_d;
      halt_q   <= halt_d;
      done_q   <= done_d;
      reason_q <= reason_d;
      trap_q   <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (any_trig) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    active   = (state_q != S_DONE);
    drain_d  = (state_q == S_DRAIN) ? drain_q + DRAIN_ONE : '0;
    cycle_d  = active ? cycle_q + ONE : cycle_q;
    commit_d = (active && inst_commit) ? commit_q + ONE : commit_q;
    log_en_d = active && inst_commit;
    log_pc_d = (active && inst_commit) ? pc : log_pc_q;
    halt_d   = (state_d != S_RUN);
    done_d   = (state_d == S_DONE);
    reason_d = reason_q;
    trap_d   = trap_q;
    // Reason and trap flag are captured only on the RUN->DRAIN edge.
    if (state_q == S_RUN && any_trig) begin
      if (cpu_ebreak_sign)   reason_d = 2'd1;
      else if (timeout_trig) reason_d = 2'd2;
      else                   reason_d = 2'd3;
      trap_d = cpu_ebreak_sign && (a0_value == '0);
    end
  end

  always_comb begin
    halt_req     = halt_q;
    log_en       = log_en_q;
    log_pc       = log_pc_q;
    sim_done     = done_q;
    halt_reason  = reason_q;
    trap_good    = trap_q;
    cycle_count  = cycle_q;
    commit_count = commit_q;
  end

endmodule

// File: tb/tb_sim_halt_ctrl.sv
// Directed bench for sim_halt_ctrl with a log scoreboard; stall tests depend on SIM_STALL_WATCHDOG_EN.
module tb_sim_halt_ctrl;
  localparam int unsigned DL   = 64;
  localparam int unsigned MAXC = 50;
  localparam int unsigned STL  = 20;
  localparam int unsigned DRN  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [DL-1:0] pc;
  logic          inst_commit;
  logic          cpu_ebreak_sign;
  logic [DL-1:0] a0_value;
  logic          halt_req;
  logic          log_en;
  logic [DL-1:0] log_pc;
  logic          sim_done;
  logic [1:0]    halt_reason;
  logic          trap_good;
  logic [DL-1:0] cycle_count;
  logic [DL-1:0] commit_count;

  sim_halt_ctrl #(
    .DATA_LEN(DL), .MAX_CYCLES(MAXC), .STALL_LIMIT(STL), .DRAIN_CYCLES(DRN)
  ) dut (
    .clock(clock), .reset(reset), .pc(pc), .inst_commit(inst_commit),
    .cpu_ebreak_sign(cpu_ebreak_sign), .a0_value(a0_value), .halt_req(halt_req),
    .log_en(log_en), .log_pc(log_pc), .sim_done(sim_done), .halt_reason(halt_reason),
    .trap_good(trap_good), .cycle_count(cycle_count), .commit_count(commit_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [DL-1:0] log_q[$];
  bit active;

  task automatic chk(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance past the edge, then check the logger against the scoreboard.
  task automatic cyc(input logic c, input logic [DL-1:0] p, input logic eb, input logic [DL-1:0] a0);
    logic [DL-1:0] e;
    inst_commit = c; pc = p; cpu_ebreak_sign = eb; a0_value = a0;
    if (c && active) log_q.push_back(p);
    @(posedge clock); #1;
    inst_commit = 1'b0; cpu_ebreak_sign = 1'b0;
    if (log_q.size() != 0) begin
      e = log_q.pop_front();
      chk("log_en", log_en, 1);
      chk("log_pc", log_pc, e);
    end else begin
      chk("log_idle", log_en, 0);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1; inst_commit = 1'b0; cpu_ebreak_sign = 1'b0; pc = '0; a0_value = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    log_q.delete();
    active = 1'b1;
    chk("rst_halt_req", halt_req, 0);
    chk("rst_log_en", log_en, 0);
    chk("rst_log_pc", log_pc, 0);
    chk("rst_sim_done", sim_done, 0);
    chk("rst_reason", halt_reason, 0);
    chk("rst_trap", trap_good, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_commits", commit_count, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ebreak with a0 == 0 on the 10th commit
    do_reset();
    cyc(1, 64'h8000_0004, 0, 0);
    chk("log_pc_80000004", log_pc, 64'h8000_0004);
    for (int i = 1; i < 9; i++) cyc(1, 64'h1000 + 64'(4 * i), 0, 0);
    cyc(1, 64'h1100, 1, 0);
    chk("eb_halt_req", halt_req, 1);
    chk("eb_reason", halt_reason, 1);
    chk("eb_trap", trap_good, 1);
    chk("eb_commits", commit_count, 10);
    chk("eb_cycles", cycle_count, 10);
    chk("eb_done_early", sim_done, 0);
    for (int i = 0; i < int'(DRN) - 1; i++) begin
      cyc(0, '0, 0, 0);
      chk("eb_drain_done", sim_done, 0);
      chk("eb_drain_halt", halt_req, 1);
    end
    cyc(0, '0, 0, 0);
    chk("eb_sim_done", sim_done, 1);
    chk("eb_cycles_final", cycle_count, 10 + DRN);
    active = 1'b0;
    cyc(1, 64'hdead, 1, 0);
    chk("eb_done_commits", commit_count, 10);
    chk("eb_done_cycles", cycle_count, 10 + DRN);
    chk("eb_done_sticky", sim_done, 1);
    chk("eb_done_reason", halt_reason, 1);

    // timeout with a commit every cycle
    do_reset();
    for (int i = 0; i < int'(MAXC) - 1; i++) cyc(1, 64'h2000 + 64'(4 * i), 0, 0);
    chk("to_pre_halt", halt_req, 0);
    chk("to_pre_cycles", cycle_count, MAXC - 1);
    cyc(1, 64'h3000, 0, 0);
    chk("to_halt_req", halt_req, 1);
    chk("to_reason", halt_reason, 2);
    chk("to_trap", trap_good, 0);
    chk("to_cycles", cycle_count, MAXC);
    for (int i = 0; i < int'(DRN); i++) cyc(1, 64'h4000 + 64'(4 * i), 0, 0);
    chk("to_sim_done", sim_done, 1);
    chk("to_cycles_final", cycle_count, MAXC + DRN);
    chk("to_commits", commit_count, MAXC + DRN);
    active = 1'b0;
    cyc(1, 64'h5000, 0, 0);
    cyc(1, 64'h5004, 0, 0);
    chk("to_frozen_cycles", cycle_count, MAXC + DRN);
    chk("to_frozen_commits", commit_count, MAXC + DRN);

    // ebreak and timeout together, then an ebreak during DRAIN, then reset at DRAIN cycle 3
    do_reset();
    for (int i = 0; i < int'(MAXC) - 1; i++) cyc(1, 64'h6000 + 64'(4 * i), 0, 0);
    cyc(1, 64'h7000, 1, 5);
    chk("both_reason", halt_reason, 1);
    chk("both_trap", trap_good, 0);
    chk("both_halt", halt_req, 1);
    cyc(0, '0, 1, 0);
    chk("drain_eb_reason", halt_reason, 1);
    chk("drain_eb_trap", trap_good, 0);
    cyc(0, '0, 0, 0);
    chk("drain3_done", sim_done, 0);
    do_reset();
    cyc(1, 64'h9000, 0, 0);
    chk("post_rst_cycles", cycle_count, 1);
    chk("post_rst_commits", commit_count, 1);
    chk("post_rst_halt", halt_req, 0);

`ifdef SIM_STALL_WATCHDOG_EN
    // stall watchdog restarted by a commit at idle 19, then fires after 20 idle cycles
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 64'ha000 + 64'(4 * i), 0, 0);
    for (int i = 0; i < int'(STL) - 1; i++) cyc(0, '0, 0, 0);
    chk("stall_pre_halt", halt_req, 0);
    cyc(1, 64'hb000, 0, 0);
    for (int i = 0; i < int'(STL) - 1; i++) cyc(0, '0, 0, 0);
    chk("stall_restart_halt", halt_req, 0);
    chk("stall_restart_reason", halt_reason, 0);
    cyc(0, '0, 0, 0);
    chk("stall_halt", halt_req, 1);
    chk("stall_reason", halt_reason, 3);
    chk("stall_trap", trap_good, 0);
`else
    // no watchdog: long idle stretch must not halt
    do_reset();
    for (int i = 0; i < 30; i++) cyc(0, '0, 0, 0);
    chk("nostall_halt", halt_req, 0);
    chk("nostall_reason", halt_reason, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sim_halt_ctrl.md
SIM_HALT_CTRL -- requirements
Module: sim_halt_ctrl

Interface
REQ-001 SHALL have parameter DATA_LEN, default 64, width of pc, a0_value, counters and log_pc.
REQ-002 SHALL have parameter MAX_CYCLES, default 400000000, cycle budget before timeout halt.
REQ-003 SHALL have parameter STALL_LIMIT, default 100000, consecutive no-commit cycles before stall halt.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 8, cycles spent in DRAIN before DONE (minimum 1).
REQ-005 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pc  input  DATA_LEN  PC of the committing instruction.
REQ-008 SHALL have port inst_commit  input  1  one instruction retires this cycle.
REQ-009 SHALL have port cpu_ebreak_sign  input  1  ebreak retired this cycle.
REQ-010 SHALL have port a0_value  input  DATA_LEN  GPR a0, sampled on ebreak.
REQ-011 SHALL have port halt_req  output  1  tells core to stop fetch.
REQ-012 SHALL have port log_en  output  1  logger write strobe.
REQ-013 SHALL have port log_pc  output  DATA_LEN  PC to log, valid when log_en.
REQ-014 SHALL have port sim_done  output  1  testbench may end simulation.
REQ-015 SHALL have port halt_reason  output  2  0 none, 1 ebreak, 2 timeout, 3 stall.
REQ-016 SHALL have port trap_good  output  1  ebreak halt with a0 == 0.
REQ-017 SHALL have port cycle_count  output  DATA_LEN  cycles elapsed since reset.
REQ-018 SHALL have port commit_count  output  DATA_LEN  instructions retired since reset.

Function
REQ-019 SHALL implement FSM RUN -> DRAIN -> DONE; DONE exits only by reset.
REQ-020 SHALL in RUN go to DRAIN next cycle on cpu_ebreak_sign, cycle_count == MAX_CYCLES-1, or stall counter == STALL_LIMIT-1 with no commit.
REQ-021 SHALL on simultaneous triggers latch one halt_reason, priority ebreak > timeout > stall.
REQ-022 SHALL latch halt_reason and trap_good (ebreak only: a0_value == 0) on the RUN->DRAIN edge; both hold until reset.
REQ-023 SHALL ignore all triggers in DRAIN and DONE.
REQ-024 SHALL assert halt_req registered, from the first DRAIN cycle through DONE.
REQ-025 SHALL stay in DRAIN exactly DRAIN_CYCLES cycles, then enter DONE; sim_done = 1 from the first DONE cycle, sticky.
REQ-026 SHALL register log_en/log_pc one cycle after inst_commit/pc in RUN or DRAIN; log_en = 0 in DONE.
REQ-027 SHALL increment cycle_count every RUN/DRAIN cycle and freeze it in DONE; no saturation needed (64-bit).
REQ-028 SHALL increment commit_count on each inst_commit in RUN/DRAIN, including the ebreak cycle's commit.
REQ-029 SHALL clear the stall counter on inst_commit and increment it otherwise in RUN only.

Reset
REQ-030 SHALL on reset enter RUN and clear all counters, halt_reason, trap_good, halt_req, log_en, log_pc, sim_done to 0.
REQ-031 SHALL on reset mid-DRAIN or in DONE return to RUN with all state cleared the next cycle.

Configuration
REQ-032 SHALL with SIM_STALL_WATCHDOG_EN defined implement the stall counter and reason 3.
REQ-033 SHALL without SIM_STALL_WATCHDOG_EN omit the stall counter; reason 3 never occurs.

Verification
REQ-034 SHALL cover: 10 commits, ebreak on 10th with a0=0 -> DRAIN next cycle, commit_count=10, reason=1, trap_good=1, sim_done DRAIN_CYCLES later.
REQ-035 SHALL cover: MAX_CYCLES=50, commit every cycle -> reason=2, cycle_count frozen at 50+DRAIN_CYCLES, trap_good=0.
REQ-036 SHALL cover (SIM_STALL_WATCHDOG_EN, STALL_LIMIT=20): commits stop -> reason=3 after 20 idle cycles; one commit at idle 19 restarts count.
REQ-037 SHALL cover: ebreak and timeout in the same cycle, a0=5 -> reason=1, trap_good=0; later ebreak in DRAIN ignored.
REQ-038 SHALL cover: reset asserted at DRAIN cycle 3 -> next cycle RUN, all outputs 0, halt_req low.
REQ-039 SHALL cover: commit with pc=0x80000004 -> log_en=1, log_pc=0x80000004 exactly one cycle later.
